// File: rtl/insn_fetch_queue.sv
// insn_fetch_queue: fetch PC, synchronous-read instruction memory with host load port,
// and a credit-limited prefetch queue feeding decode over valid/ready.
module insn_fetch_queue #(
    parameter logic [31:0] START_ADDR  = 32'h8000_0000,
    parameter int          IMEM_AW     = 12,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic [31:0]                    insn_addr,
    input  logic [31:0]                    insn_din,
    input  logic                           insn_we,
    input  logic [31:0]                    redirect_pc,
    input  logic                           redirect_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [31:0]                    out_insn,
    output logic [31:0]                    fetch_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
    localparam int QA = $clog2(QUEUE_DEPTH);

    logic [31:0]   mem [2**IMEM_AW];
    logic [31:0]   q_pc [QUEUE_DEPTH];
    logic [31:0]   q_insn [QUEUE_DEPTH];
    logic [31:0]   fpc, rdata, inflight_pc;
    logic          inflight_v;
    logic [QA-1:0] head, tail;
    logic [QA:0]   count;
    logic [QA+1:0] occ;
    logic          flush, issue, push, pop;
    logic          unused;

    assign unused      = ^{insn_addr[31:IMEM_AW+2], insn_addr[1:0], redirect_pc[1:0]};
    assign flush       = reset || !run || redirect_en;
    // Credits cover both queued and in-flight words, so a push never meets a full queue
    assign occ         = {1'b0, count} + (QA+2)'(inflight_v);
    assign issue       = !flush && occ < (QA+2)'(QUEUE_DEPTH);
    assign push        = !flush && inflight_v;
    assign pop         = !flush && out_valid && out_ready;
    assign out_valid   = count != '0;
    assign out_pc      = q_pc[head];
    assign out_insn    = q_insn[head];
    assign fetch_pc    = fpc;
    assign queue_count = count;

    always_ff @(posedge clk) begin
        if (insn_we) mem[insn_addr[IMEM_AW+1:2]] <= insn_din;
        rdata <= mem[fpc[IMEM_AW+1:2]];
        if (push) begin
            q_pc[tail]   <= inflight_pc;
            q_insn[tail] <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            fpc        <= (reset || !run) ? START_ADDR : {redirect_pc[31:2], 2'b00};
            inflight_v <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            if (issue) fpc <= fpc + 32'd4;
            inflight_v  <= issue;
            inflight_pc <= fpc;
            if (push) tail <= tail + QA'(1);
            if (pop) head <= head + QA'(1);
            count <= count + (QA+1)'(push) - (QA+1)'(pop);
        end
    end
endmodule

// File: tb/tb_insn_fetch_queue.sv
// tb_insn_fetch_queue: queue-based reference model compared every cycle, plus directed
// literal expectations for startup, backpressure, redirect, run drop, wrap and read-during-write.
module tb_insn_fetch_queue;
    localparam logic [31:0] START = 32'h8000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, run, insn_we, redirect_en, out_ready;
    logic [31:0] insn_addr, insn_din, redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc, out_insn, fetch_pc;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    insn_fetch_queue #(.START_ADDR(START), .IMEM_AW(12), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .run(run), .insn_addr(insn_addr), .insn_din(insn_din),
        .insn_we(insn_we), .redirect_pc(redirect_pc), .redirect_en(redirect_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn),
        .fetch_pc(fetch_pc), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        return {16'hC0DE, 4'h0, 12'(i)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words still owed by memory plus an ordered list of deliverable words
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mm [4096];
    logic [31:0] m_fpc, m_infl_pc, m_infl_data;
    bit          m_infl = 1'b0;

    always @(posedge clk) begin
        bit          fl, iss, pp;
        logic [31:0] rd;
        fl  = reset || !run || redirect_en;
        iss = !fl && (mq.size() + int'(m_infl) < DEPTH);
        pp  = !fl && mq.size() > 0 && out_ready;
        rd  = mm[m_fpc[13:2]];
        if (insn_we) mm[insn_addr[13:2]] = insn_din;
        if (fl) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = (reset || !run) ? START : {redirect_pc[31:2], 2'b00};
        end else begin
            if (pp) void'(mq.pop_front());
            if (m_infl) mq.push_back('{m_infl_pc, m_infl_data});
            m_infl      = iss;
            m_infl_pc   = m_fpc;
            m_infl_data = rd;
            if (iss) m_fpc = m_fpc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("model_count", 32'(queue_count), 32'(mq.size()));
            chk("model_fpc", fetch_pc, m_fpc);
            if (mq.size() > 0) begin
                chk("model_pc", out_pc, mq[0].pc);
                chk("model_insn", out_insn, mq[0].insn);
            end
        end
    end

    initial begin
        reset = 1; run = 1; out_ready = 1; redirect_en = 0; redirect_pc = 0;
        insn_we = 0; insn_addr = 0; insn_din = 0;
        tick();
        for (int i = 0; i < 4096; i++) begin
            insn_we = 1; insn_addr = START + 32'(i) * 4; insn_din = pat(i);
            tick();
        end
        insn_we = 0;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_fpc", fetch_pc, START);
        // Startup: cycle 0 issues START_ADDR, valid in cycle 2
        tick(); reset = 0;
        @(negedge clk);
        chk("c0_valid", 32'(out_valid), 0);
        chk("c0_fpc", fetch_pc, 32'h8000_0000);
        tick(); @(negedge clk);
        chk("c1_valid", 32'(out_valid), 0);
        chk("c1_fpc", fetch_pc, 32'h8000_0004);
        tick(); @(negedge clk);
        chk("c2_valid", 32'(out_valid), 1);
        chk("c2_pc", out_pc, 32'h8000_0000);
        chk("c2_insn", out_insn, 32'hC0DE_0000);
        for (int i = 1; i < 8; i++) begin
            tick(); @(negedge clk);
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_pc", out_pc, 32'h8000_0000 + 32'(i) * 4);
            chk("stream_insn", out_insn, pat(i));
        end
        // run dropped for two cycles
        tick(); run = 0;
        tick(); @(negedge clk);
        chk("run0_valid", 32'(out_valid), 0);
        chk("run0_fpc", fetch_pc, 32'h8000_0000);
        tick(); run = 1; out_ready = 0;
        // Backpressure from the refetch
        repeat (8) tick();
        @(negedge clk);
        chk("bp_count", 32'(queue_count), 4);
        chk("bp_fpc", fetch_pc, 32'h8000_0010);
        chk("bp_pc", out_pc, 32'h8000_0000);
        chk("bp_insn", out_insn, 32'hC0DE_0000);
        tick(); out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rel_valid", 32'(out_valid), 1);
            chk("rel_pc", out_pc, 32'h8000_0000 + 32'(i) * 4);
            tick();
        end
        // Redirect with three queued entries and a simultaneous pop
        out_ready = 0;
        repeat (8) tick();
        out_ready = 1;
        tick(); redirect_en = 1; redirect_pc = 32'h8000_0041;
        @(negedge clk);
        chk("pre_redir_count", 32'(queue_count), 3);
        tick(); redirect_en = 0;
        @(negedge clk);
        chk("redir_count", 32'(queue_count), 0);
        chk("redir_valid1", 32'(out_valid), 0);
        chk("redir_fpc", fetch_pc, 32'h8000_0040);
        tick(); @(negedge clk);
        chk("redir_valid2", 32'(out_valid), 0);
        tick(); @(negedge clk);
        chk("redir_valid3", 32'(out_valid), 1);
        chk("redir_pc", out_pc, 32'h8000_0040);
        chk("redir_insn", out_insn, 32'hC0DE_0010);
        // Address wrap at the top of the 32-bit space
        tick(); redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect_en = 0;
        tick(); tick(); @(negedge clk);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        chk("wrap_insn0", out_insn, 32'hC0DE_0FFF);
        tick(); @(negedge clk);
        chk("wrap_pc1", out_pc, 32'h0000_0000);
        chk("wrap_insn1", out_insn, 32'hC0DE_0000);
        // Host write to the word being fetched returns old data; refetch sees new data
        tick(); redirect_en = 1; redirect_pc = 32'h8000_0100;
        tick(); redirect_en = 0; insn_we = 1; insn_addr = 32'h8000_0100; insn_din = 32'hDEAD_BEEF;
        tick(); insn_we = 0;
        tick(); @(negedge clk);
        chk("rdw_pc", out_pc, 32'h8000_0100);
        chk("rdw_old", out_insn, 32'hC0DE_0040);
        tick(); redirect_en = 1;
        tick(); redirect_en = 0;
        tick(); tick(); @(negedge clk);
        chk("rdw_pc2", out_pc, 32'h8000_0100);
        chk("rdw_new", out_insn, 32'hDEAD_BEEF);
        repeat (4) tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
